fc_argmax_ctrl: RTL
===================

// Module: fc_argmax_ctrl
// PURPOSE
//  Drives the enable/done handshake of the N_CLASS final fully-connected neurons (fc0..fc9), one per class.
//  - Holds the shared enable high until every neuron reports done.
//  - Captures all signed ACC_W-bit neuron outputs in the same cycle.
//  - Runs a sequential signed argmax over them and reports the winning class index and score.
//  - Sits between the network top-level sequencer (start/result) and the FC output layer.
// PARAMETERS
//  N_CLASS      10     number of FC output neurons / classes (>=2)
//  ACC_W        38     signed width of each neuron output
//  IDX_W        4      width of class index; must satisfy 2**IDX_W >= N_CLASS
//  TIMEOUT_CYC  8192   max cycles in RUN waiting for all done before error
// PORTS
//  clk           in   1                clock, all logic on rising edge
//  rst           in   1                asynchronous, active-high reset
//  start         in   1                request one classification; sampled only in IDLE
//  busy          out  1                high in every state except IDLE
//  fc_enable     out  1                shared enable to all FC neurons
//  fc_done       in   N_CLASS          done flag per neuron, bit i = neuron i
//  fc_out        in   N_CLASS*ACC_W    neuron outputs, signed; neuron i at [i*ACC_W +: ACC_W]
//  class_idx     out  IDX_W            index of winning class
//  class_score   out  ACC_W            signed score of winning class
//  result_valid  out  1                one-cycle pulse: class_idx/class_score are new
//  timeout_err   out  1                one-cycle pulse: RUN aborted on timeout
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; fc_enable, busy, result_valid, timeout_err, class_idx, class_score = 0.
//   - Score regs, scan index and timeout counter are cleared.
//   - fc_enable drops immediately on rst, so the neurons clear their accumulators.
//  FSM: IDLE -> RUN -> SCAN -> DONE -> IDLE; RUN -> IDLE on timeout.
//  IDLE: start=1 at edge k -> RUN; fc_enable=1 from cycle k+1; timeout counter cleared.
//  RUN: fc_enable=1; counter increments each cycle.
//   - At the first edge m where &fc_done=1: latch all N_CLASS fc_out slices into score regs, go to SCAN.
//   - fc_enable=0 from cycle m+1.
//   - The capture must occur while fc_enable is still high, because the neurons zero their outputs when enable drops.
//   - Partial done (some bits low) keeps waiting; done bits need not rise together.
//   - If the counter reaches TIMEOUT_CYC-1 with &fc_done still 0: go to IDLE.
//     - timeout_err=1 for one cycle; fc_enable=0.
//     - class_idx/class_score unchanged; no result_valid.
//   - If &fc_done and timeout occur at the same edge, done wins.
//  SCAN: one compare per cycle, N_CLASS cycles (i=0..N_CLASS-1).
//   - i=0 loads best=score[0], best_idx=0.
//   - i>0 replaces best only if score[i] > best (signed, strict): ties keep the lower index.
//   - After i=N_CLASS-1 -> DONE, with class_idx/class_score updated at that edge.
//  DONE: result_valid=1 for exactly one cycle -> IDLE.
//   - Result latency: result_valid is high in cycle m+N_CLASS+1.
//  Outputs class_idx/class_score hold until the next DONE or reset.
//  start while busy is ignored (not queued). start in the DONE cycle is ignored; it is accepted in IDLE.
//  No arithmetic beyond signed ACC_W comparison; no width growth.
// TESTING
//  T1 reset: assert rst mid-RUN (fc_enable=1) -> fc_enable, busy, outputs 0 asynchronously; state IDLE after release.
//  T2 basic: scores {-5,3,100,7,0,-1,2,99,4,1}, all done 20 cycles after start.
//   -> class_idx=2, class_score=100; result_valid one cycle, 11 cycles after capture edge.
//  T3 tie/negatives: all scores -7 -> class_idx=0, class_score=-7.
//   - scores[3]=scores[8]=2**37-1 (others 0) -> class_idx=3.
//  T4 staggered done: bits rise one per cycle, 0..9.
//   - Capture happens only on the edge bit 9 is seen with all bits high.
//   - fc_enable stays high until then.
//  T5 timeout: TIMEOUT_CYC=16, fc_done=10'h1FF stuck.
//   -> timeout_err pulse at cycle 16 after start; no result_valid; previous class_idx retained.
//  T6 start while busy: pulse start during SCAN -> ignored; exactly one result_valid; a new start in IDLE begins a second run.

Source files
------------

// File: rtl/fc_argmax_ctrl.sv
// fc_argmax_ctrl
// Controls the enable/done handshake for the final fully-connected layer
// (one neuron per class) and picks the winning class.
//  - Raises the shared fc_enable on start and keeps it high until every
//    neuron reports done. All outputs are captured on that same edge.
//  - Runs a sequential signed argmax with one compare per cycle.
//    On equal scores the lower class index wins.
//  - Aborts with a one-cycle timeout_err pulse if done never completes.
// Ports:
//  clk, rst        clock (rising edge); asynchronous active-high reset
//  start           classification request, sampled only while idle
//  busy            high whenever the controller is not idle
//  fc_enable       shared enable to all FC neurons
//  fc_done         per-neuron done flags (bit i = neuron i)
//  fc_out          packed signed neuron outputs, neuron i at [i*ACC_W +: ACC_W]
//  class_idx       winning class index (held until next result or reset)
//  class_score     winning class score (held until next result or reset)
//  result_valid    one-cycle pulse when class_idx/class_score are new
//  timeout_err     one-cycle pulse when a run is aborted on timeout
module fc_argmax_ctrl #(
  parameter int N_CLASS     = 10,
  parameter int ACC_W       = 38,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      fc_enable,
  input  logic [N_CLASS-1:0]        fc_done,
  input  logic [N_CLASS*ACC_W-1:0]  fc_out,
  output logic [IDX_W-1:0]          class_idx,
  output logic signed [ACC_W-1:0]   class_score,
  output logic                      result_valid,
  output logic                      timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         run_cnt;
  logic [IDX_W-1:0]         scan_idx;
  logic [IDX_W-1:0]         best_idx;
  logic signed [ACC_W-1:0]  best;
  logic signed [ACC_W-1:0]  score [N_CLASS];
  logic signed [ACC_W-1:0]  fc_slice [N_CLASS];

  // Unpack the neuron outputs so the capture is a plain per-element copy.
  generate
    for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_slice
      assign fc_slice[gi] = fc_out[gi*ACC_W +: ACC_W];
    end
  endgenerate

  // Candidate for this scan step. Index 0 always seeds the running best.
  // A strict '>' keeps the lower index when scores are equal.
  logic signed [ACC_W-1:0] cur_score;
  logic                    take_cur;
  logic signed [ACC_W-1:0] best_next;
  logic [IDX_W-1:0]        best_idx_next;

  always_comb begin
    cur_score     = score[scan_idx];
    take_cur      = (scan_idx == '0) || (cur_score > best);
    best_next     = take_cur ? cur_score : best;
    best_idx_next = take_cur ? scan_idx : best_idx;
  end

  // Decoded from the state register, so it drops the moment rst forces IDLE.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fc_enable    <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      run_cnt      <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best         <= '0;
      for (int i = 0; i < N_CLASS; i++) score[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          run_cnt <= '0;
          if (start) begin
            state     <= RUN;
            fc_enable <= 1'b1;
          end
        end
        RUN: begin
          // Capture on the edge where all done bits are seen, while enable
          // is still high: the neurons clear their outputs once it drops.
          // Done takes priority over a coincident timeout.
          if (&fc_done) begin
            for (int i = 0; i < N_CLASS; i++) score[i] <= fc_slice[i];
            fc_enable <= 1'b0;
            scan_idx  <= '0;
            state     <= SCAN;
          end else if (run_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            fc_enable   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            run_cnt <= run_cnt + CNT_W'(1);
          end
        end
        SCAN: begin
          best     <= best_next;
          best_idx <= best_idx_next;
          if (scan_idx == IDX_W'(N_CLASS - 1)) begin
            class_idx    <= best_idx_next;
            class_score  <= best_next;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        DONE: begin
          // start is deliberately not sampled here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
